// File: rtl/nios_cpu_spi_txn_arbiter_pkg.sv
// Shared constants, state encodings and the poll-branch helper for the SPI transaction arbiter.
package nios_cpu_spi_txn_pkg;

    localparam logic [2:0] REG_RX      = 3'd0;
    localparam logic [2:0] REG_TX      = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_SSEL    = 3'd5;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TMT  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int SSO_BIT = 10;

    typedef enum logic [3:0] {
        S_IDLE, S_SSEL, S_SSO_ON, S_TRDY0, S_TX0, S_RRDY0, S_RX0, S_TRDY1,
        S_TX1, S_RRDY1, S_RX1, S_TMT, S_ERR_CLR, S_SSO_OFF, S_DONE
    } txn_state_e;

    typedef enum logic [1:0] {BA_IDLE, BA_A1, BA_A2, BA_GAP} bus_state_e;

    function automatic txn_state_e poll_next(input logic ready, input logic tmo,
                                             input txn_state_e hit, input txn_state_e cur);
        if (ready) return hit;
        if (tmo)   return S_SSO_OFF;
        return cur;
    endfunction

endpackage

// File: rtl/nios_cpu_spi_txn_arbiter_if.sv
// Avalon-style register port of the SPI master core, as seen from the arbiter (master) and core (slave).
interface nios_cpu_spi_txn_arbiter_if;
    logic        spi_select;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_wdata;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_rdata;

    modport master (output spi_select, spi_mem_addr, spi_wdata, spi_read_n, spi_write_n,
                    input  spi_rdata);
    modport slave  (input  spi_select, spi_mem_addr, spi_wdata, spi_read_n, spi_write_n,
                    output spi_rdata);
endinterface

// File: rtl/nios_cpu_spi_txn_arbiter_bus_access.sv
// Three-cycle register access sequencer: A1, A2 drive the strobe, G is the idle gap the core needs.
module nios_cpu_spi_bus_access
    import nios_cpu_spi_txn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        rd_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [7:0]  rdata_o,
    output logic        spi_select_o,
    output logic [2:0]  spi_mem_addr_o,
    output logic [15:0] spi_wdata_o,
    output logic        spi_read_n_o,
    output logic        spi_write_n_o,
    input  logic [15:0] spi_rdata_i
);
    bus_state_e  state_q, state_d;
    logic        rd_q, ack_q, active;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  rdata_q;
    logic        unused_rdata_hi;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BA_IDLE: if (start_i) state_d = BA_A1;
            BA_A1:   state_d = BA_A2;
            BA_A2:   state_d = BA_GAP;
            default: state_d = BA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BA_IDLE;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_q == BA_GAP);
            if (state_q == BA_IDLE && start_i) begin
                rd_q    <= rd_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (state_q == BA_A2) rdata_q <= spi_rdata_i[7:0];
        end
    end

    assign active          = (state_q == BA_A1) || (state_q == BA_A2);
    assign busy_o          = (state_q != BA_IDLE);
    assign ack_o           = ack_q;
    assign rdata_o         = rdata_q;
    assign spi_select_o    = active;
    assign spi_read_n_o    = !(active && rd_q);
    assign spi_write_n_o   = !(active && !rd_q);
    assign spi_mem_addr_o  = addr_q;
    assign spi_wdata_o     = wdata_q;
    assign unused_rdata_hi = ^spi_rdata_i[15:8];

endmodule

// File: rtl/nios_cpu_spi_txn_arbiter.sv
// Round-robin owner of the SPI core: one 2-byte register transaction per grant.
// Poll timeout is compiled in with SPI_TXN_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | arbitrate, latch winner's fields
//   SSEL      | write slave-enable mask
//   SSO_ON    | force slave select on
//   TRDYn     | poll status until TX ready
//   TXn       | write byte n
//   RRDYn     | poll status until RX ready
//   RXn       | read rx (byte 1 is the result)
//   TMT       | poll status until shifter empty
//   ERR_CLR   | clear ROE/TOE via status write
//   SSO_OFF   | release slave select
//   DONE      | done pulse, advance pointer
module nios_cpu_spi_txn_arbiter
    import nios_cpu_spi_txn_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   req_rd_i,
    input  logic [NUM_REQ-1:0]   req_slave_i,
    input  logic [NUM_REQ*7-1:0] req_addr_i,
    input  logic [NUM_REQ*8-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 done_o,
    output logic [7:0]           rdata_o,
    output logic                 err_o,
    nios_cpu_spi_txn_arbiter_if.master spi
);
    txn_state_e         state_q, state_d;
    logic               ptr_q, ptr_d, win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               err_q, err_d, wait_q, wait_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rd_q, slave_q;
    logic [6:0]         addr_q;
    logic [7:0]         wdata_q;
    logic               latch, poll_st, poll_ready, timed_out;
    logic               bus_start, bus_rd, bus_busy, bus_ack;
    logic [2:0]         bus_addr;
    logic [15:0]        bus_wdata, ssel_data;
    logic [7:0]         bus_rdata;

    assign ssel_data = (16'(1) << slave_q) & 16'((1 << NUM_SLAVES) - 1);

`ifdef SPI_TXN_TIMEOUT_EN
    logic [11:0] poll_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    poll_cnt_q <= '0;
        else if (state_d != state_q)  poll_cnt_q <= '0;
        else if (poll_cnt_q != '1)    poll_cnt_q <= poll_cnt_q + 12'd1;
    end

    // Only evaluated when a status read returns, so an in-flight access is never cut short.
    assign timed_out = (poll_cnt_q >= 12'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = ^12'(TIMEOUT_CYCLES);
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        grant_d    = grant_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        wait_d     = wait_q;
        latch      = 1'b0;
        bus_start  = 1'b0;
        bus_rd     = 1'b0;
        bus_addr   = REG_STATUS;
        bus_wdata  = '0;
        poll_st    = state_q inside {S_TRDY0, S_RRDY0, S_TRDY1, S_RRDY1, S_TMT};
        poll_ready = bus_rdata[ST_TMT];
        if (state_q inside {S_TRDY0, S_TRDY1}) poll_ready = bus_rdata[ST_TRDY];
        if (state_q inside {S_RRDY0, S_RRDY1}) poll_ready = bus_rdata[ST_RRDY];

        if (poll_st && bus_ack) begin
            if (bus_rdata[ST_ROE] || bus_rdata[ST_TOE]) err_d = 1'b1;
            if (!poll_ready && timed_out)               err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: if (|req_i) begin
                win_d   = req_i[ptr_q] ? ptr_q : ~ptr_q;
                grant_d = NUM_REQ'(1) << win_d;
                err_d   = 1'b0;
                latch   = 1'b1;
                state_d = S_SSEL;
            end
            S_SSEL: begin
                bus_addr  = REG_SSEL;
                bus_wdata = ssel_data;
                if (bus_ack) state_d = S_SSO_ON;
            end
            S_SSO_ON: begin
                bus_addr  = REG_CONTROL;
                bus_wdata = 16'(1) << SSO_BIT;
                if (bus_ack) state_d = S_TRDY0;
            end
            S_TRDY0: begin
                bus_rd = 1'b1;
                if (bus_ack) state_d = poll_next(poll_ready, timed_out, S_TX0, state_q);
            end
            S_TX0: begin
                bus_addr  = REG_TX;
                bus_wdata = {8'h00, rd_q, addr_q};
                if (bus_ack) state_d = S_RRDY0;
            end
            S_RRDY0: begin
                bus_rd = 1'b1;
                if (bus_ack) state_d = poll_next(poll_ready, timed_out, S_RX0, state_q);
            end
            S_RX0: begin
                bus_rd   = 1'b1;
                bus_addr = REG_RX;
                if (bus_ack) state_d = S_TRDY1;
            end
            S_TRDY1: begin
                bus_rd = 1'b1;
                if (bus_ack) state_d = poll_next(poll_ready, timed_out, S_TX1, state_q);
            end
            S_TX1: begin
                bus_addr  = REG_TX;
                bus_wdata = rd_q ? 16'h0000 : {8'h00, wdata_q};
                if (bus_ack) state_d = S_RRDY1;
            end
            S_RRDY1: begin
                bus_rd = 1'b1;
                if (bus_ack) state_d = poll_next(poll_ready, timed_out, S_RX1, state_q);
            end
            S_RX1: begin
                bus_rd   = 1'b1;
                bus_addr = REG_RX;
                if (bus_ack) begin
                    if (rd_q) rdata_d = bus_rdata;
                    state_d = S_TMT;
                end
            end
            S_TMT: begin
                bus_rd = 1'b1;
                if (bus_ack)
                    state_d = poll_next(poll_ready, timed_out,
                                        err_d ? S_ERR_CLR : S_SSO_OFF, state_q);
            end
            S_ERR_CLR: begin
                bus_addr = REG_STATUS;
                if (bus_ack) state_d = S_SSO_OFF;
            end
            S_SSO_OFF: begin
                bus_addr = REG_CONTROL;
                if (bus_ack) state_d = S_DONE;
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = ~win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state except IDLE/DONE issues exactly one access and waits for its ack.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (!wait_q && !bus_busy) begin
                bus_start = 1'b1;
                wait_d    = 1'b1;
            end
            if (bus_ack) wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            grant_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wait_q  <= 1'b0;
            rd_q    <= 1'b0;
            slave_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            if (latch) begin
                rd_q    <= req_rd_i[win_d];
                slave_q <= req_slave_i[win_d];
                addr_q  <= req_addr_i[int'(win_d) * 7 +: 7];
                wdata_q <= req_wdata_i[int'(win_d) * 8 +: 8];
            end
        end
    end

    assign grant_o = grant_q;
    assign done_o  = (state_q == S_DONE);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    nios_cpu_spi_bus_access u_bus (
        .clk            (clk),
        .reset          (reset),
        .start_i        (bus_start),
        .rd_i           (bus_rd),
        .addr_i         (bus_addr),
        .wdata_i        (bus_wdata),
        .busy_o         (bus_busy),
        .ack_o          (bus_ack),
        .rdata_o        (bus_rdata),
        .spi_select_o   (spi.spi_select),
        .spi_mem_addr_o (spi.spi_mem_addr),
        .spi_wdata_o    (spi.spi_wdata),
        .spi_read_n_o   (spi.spi_read_n),
        .spi_write_n_o  (spi.spi_write_n),
        .spi_rdata_i    (spi.spi_rdata)
    );

endmodule

// File: tb/tb_nios_cpu_spi_txn_arbiter.sv
// Bench: behavioural SPI core + loopback slave, transaction-level expected write log per grant.
module tb_nios_cpu_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_rd, req_slave;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  grant;
    logic        done, err;
    logic [7:0]  rdata;

    always #5 clk = ~clk;

    nios_cpu_spi_txn_arbiter_if bus_if ();

    nios_cpu_spi_txn_arbiter #(.NUM_REQ(2), .NUM_SLAVES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .req_rd_i    (req_rd),
        .req_slave_i (req_slave),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .grant_o     (grant),
        .done_o      (done),
        .rdata_o     (rdata),
        .err_o       (err),
        .spi         (bus_if)
    );

    // core model: 0 normal, 1 ROE stuck set, 2 status stuck at zero
    int          mode = 0;
    logic [7:0]  rsp = 8'h00;
    logic [15:0] m_ssel = 16'h0, m_ctrl = 16'h0;
    logic [7:0]  m_rx = 8'h00;
    int          m_bytes = 0;
    logic        prev_w = 1'b0, prev_r = 1'b0;
    logic        wr_act, rd_act;
    logic [22:0] wlog[$];   // {ss_n, grant, addr, data} per write access

    assign wr_act = bus_if.spi_select && !bus_if.spi_write_n;
    assign rd_act = bus_if.spi_select && !bus_if.spi_read_n;

    always @(posedge clk) begin
        prev_w <= wr_act;
        prev_r <= rd_act;
        if (wr_act && !prev_w) begin
            wlog.push_back({~(m_ssel[1:0] & {2{m_ctrl[10]}}), grant,
                            bus_if.spi_mem_addr, bus_if.spi_wdata});
            case (bus_if.spi_mem_addr)
                3'd5: m_ssel <= bus_if.spi_wdata;
                3'd3: begin
                    m_ctrl <= bus_if.spi_wdata;
                    if (bus_if.spi_wdata[10]) m_bytes <= 0;
                end
                3'd1: begin
                    m_rx    <= (m_bytes == 0) ? 8'hEE : rsp;
                    m_bytes <= m_bytes + 1;
                end
                default: ;
            endcase
        end
        if (rd_act && !prev_r) begin
            if (bus_if.spi_mem_addr == 3'd0)
                bus_if.spi_rdata <= {8'h00, m_rx};
            else if (bus_if.spi_mem_addr == 3'd2) begin
                if (mode == 2 || $urandom_range(0, 3) == 0) bus_if.spi_rdata <= 16'h0000;
                else bus_if.spi_rdata <= {8'h00, 8'hE0 | ((mode == 1) ? 8'h08 : 8'h00)};
            end else
                bus_if.spi_rdata <= 16'h0000;
        end
    end

    int         checks = 0;
    int         errors = 0;
    bit         ptr = 1'b0;
    logic [7:0] exp_rdata = 8'h00;
    int         w;
    bit         found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic new_fields(input int r);
        req_rd[r]            = 1'($urandom_range(0, 1));
        req_slave[r]         = 1'($urandom_range(0, 1));
        req_addr[r*7 +: 7]   = 7'($urandom);
        req_wdata[r*8 +: 8]  = 8'($urandom);
    endtask

    task automatic serve(input string tag, input logic [7:0] rsp_in, input bit roe,
                         input bit tmo, input int budget, output int win);
        bit          ok;
        logic        rd, slv;
        logic [6:0]  ad;
        logic [7:0]  wd;
        logic [1:0]  gexp, ssexp;
        logic [20:0] exp_q[$];
        int          n;
        rsp   = rsp_in;
        win   = req[ptr] ? int'(ptr) : int'(!ptr);
        rd    = req_rd[win];
        slv   = req_slave[win];
        ad    = req_addr[win*7 +: 7];
        wd    = req_wdata[win*8 +: 8];
        gexp  = 2'(2'b01 << win);
        ssexp = ~(2'(2'b01 << slv));
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (done === 1'b1);
        end
        check({tag, " done seen"}, 32'(ok), 32'd1);
        check({tag, " grant"}, 32'(grant), 32'(gexp));
        exp_q.push_back({gexp, 3'd5, 16'(2'b01 << slv)});
        exp_q.push_back({gexp, 3'd3, 16'h0400});
        if (!tmo) begin
            exp_q.push_back({gexp, 3'd1, 8'h00, rd, ad});
            exp_q.push_back({gexp, 3'd1, rd ? 16'h0000 : {8'h00, wd}});
            if (roe) exp_q.push_back({gexp, 3'd2, 16'h0000});
            if (rd) exp_rdata = rsp_in;
        end
        exp_q.push_back({gexp, 3'd3, 16'h0000});
        check({tag, " err"}, 32'(err), 32'(roe || tmo));
        check({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
        check({tag, " write count"}, 32'(wlog.size()), 32'(exp_q.size()));
        n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " write"}, 32'(wlog[i][20:0]), 32'(exp_q[i]));
            if (exp_q[i][18:16] == 3'd1)
                check({tag, " ss_n"}, 32'(wlog[i][22:21]), 32'(ssexp));
        end
        wlog.delete();
        ptr = (win == 0);
    endtask

    initial begin
        reset = 1'b1;
        req = '0; req_rd = '0; req_slave = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst grant", 32'(grant), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rdata", 32'(rdata), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst select", 32'(bus_if.spi_select), 32'd0);
        check("rst read_n", 32'(bus_if.spi_read_n), 32'd1);
        check("rst write_n", 32'(bus_if.spi_write_n), 32'd1);
        check("rst mem_addr", 32'(bus_if.spi_mem_addr), 32'd0);
        check("rst wdata", 32'(bus_if.spi_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // directed write from requester 0, then read from requester 1
        req_rd[0] = 1'b0; req_slave[0] = 1'b0; req_addr[6:0] = 7'h12; req_wdata[7:0] = 8'hA5;
        req = 2'b01;
        serve("wr0", 8'h5A, 1'b0, 1'b0, 3000, w);
        req_rd[1] = 1'b1; req_slave[1] = 1'b1; req_addr[13:7] = 7'h05; req_wdata[15:8] = 8'h77;
        req = 2'b10;
        serve("rd1", 8'h3C, 1'b0, 1'b0, 3000, w);

        // both held high: grants must alternate
        new_fields(0); new_fields(1);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve("rr", 8'($urandom), 1'b0, 1'b0, 3000, w);
            new_fields(w);
        end

        for (int k = 0; k < 8; k++) begin
            new_fields(0); new_fields(1);
            req = 2'($urandom_range(1, 3));
            serve("rand", 8'($urandom), 1'b0, 1'b0, 3000, w);
        end

        mode = 1;
        new_fields(0);
        req = 2'b01;
        serve("roe", 8'($urandom), 1'b1, 1'b0, 3000, w);
        mode = 0;

        // reset while the second data byte is being written
        new_fields(0);
        req = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (wlog.size() == 4);
        end
        check("tx1 reached", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst grant", 32'(grant), 32'd0);
        check("midrst select", 32'(bus_if.spi_select), 32'd0);
        check("midrst read_n", 32'(bus_if.spi_read_n), 32'd1);
        check("midrst write_n", 32'(bus_if.spi_write_n), 32'd1);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ptr = 1'b0;
        exp_rdata = 8'h00;
        check("midrst rdata", 32'(rdata), 32'd0);
        wlog.delete();
        new_fields(1);
        req_rd[1] = 1'b1;
        req = 2'b10;
        serve("post rst", 8'($urandom), 1'b0, 1'b0, 3000, w);

`ifdef SPI_TXN_TIMEOUT_EN
        mode = 2;
        new_fields(0);
        req = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = (wlog.size() == 2);
        end
        check("tmo sso on", 32'(found), 32'd1);
        serve("timeout", 8'($urandom), 1'b0, 1'b1, 80, w);
        mode = 0;
`endif

        req = 2'b00;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
